// File: rtl/pong_input_ctrl.sv
// Input front end for the pong light game: synchronizes and debounces the serve
// and paddle buttons, generates the free-running step clock and the b/p requests.
module pong_input_ctrl #(
   parameter int DIV       = 25_000_000,
   parameter int DB_CYCLES = 500_000
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       serve_btn,
   input  logic       paddle_btn,
   input  logic [7:0] led_in,
   output logic       step_clk,
   output logic       b,
   output logic       p,
   output logic       lockout
);

   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

   // bit 0 = serve, bit 1 = paddle
   logic [1:0]       sync_p0, sync_p1;
   logic [1:0]       db_lvl, db_lvl_d;
   logic [DB_W-1:0]  db_cnt [2];
   logic [1:0]       press;

   logic [DIV_W-1:0] div_cnt;
   logic             fall;
   logic             serve_pend, hit_pend;
   logic             at_top, at_bot;
   logic             hit_set, lock_set;

   assign press    = db_lvl & ~db_lvl_d;
   assign fall     = (div_cnt == DIV_LAST) && step_clk;
   assign at_top   = (led_in == 8'h01);
   assign at_bot   = (led_in == 8'h80);
   assign hit_set  = press[1] && !lockout && at_top;
   assign lock_set = press[1] && !lockout && !at_top;

   // Stage p0/p1: two-flop synchronizer, then debounce on the p1 value
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_p0  <= '0;
         sync_p1  <= '0;
         db_lvl   <= '0;
         db_lvl_d <= '0;
         for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      end else begin
         sync_p0  <= {paddle_btn, serve_btn};
         sync_p1  <= sync_p0;
         db_lvl_d <= db_lvl;
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] == db_lvl[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_lvl[i] <= sync_p1[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Step divider and request generation; a press on a fall cycle re-arms its pend
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         div_cnt    <= '0;
         step_clk   <= 1'b0;
         serve_pend <= 1'b0;
         hit_pend   <= 1'b0;
         b          <= 1'b0;
         p          <= 1'b0;
         lockout    <= 1'b0;
      end else begin
         if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            step_clk <= ~step_clk;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         if (fall) begin
            b          <= serve_pend;
            p          <= hit_pend;
            serve_pend <= press[0];
            hit_pend   <= hit_set;
         end else begin
            if (press[0]) serve_pend <= 1'b1;
            if (hit_set)  hit_pend   <= 1'b1;
         end

         if (at_bot)        lockout <= 1'b0;
         else if (lock_set) lockout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pong_input_ctrl.sv
// Scoreboard bench for pong_input_ctrl: a cycle-count reference model predicts
// {step_clk,b,p,lockout} after each edge; a negedge monitor compares.
module tb_pong_input_ctrl;

   localparam int DIV = 4;
   localparam int DB  = 3;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       serve_btn = 1'b0;
   logic       paddle_btn = 1'b0;
   logic [7:0] led_in = 8'h00;
   logic       step_clk, b, p, lockout;

   int vectors = 0;
   int miscompares = 0;
   logic [3:0] exp_q [$];

   // reference model state
   int k;
   bit s_hist [$], p_hist [$];
   bit s_win [$], p_win [$];
   bit s_lvl, p_lvl, s_rose, p_rose;
   bit m_serve_pend, m_hit_pend, m_b, m_p, m_lock, m_step;

   pong_input_ctrl #(.DIV(DIV), .DB_CYCLES(DB)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .serve_btn(serve_btn), .paddle_btn(paddle_btn),
      .led_in(led_in), .step_clk(step_clk), .b(b), .p(p), .lockout(lockout)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b ({step_clk,b,p,lockout}) at %0t", name, act, exp_v, $time);
      end
   endtask

   function automatic bit all_differ(input bit w [$], input bit lvl);
      if (w.size() != DB) return 1'b0;
      foreach (w[i]) if (w[i] == lvl) return 1'b0;
      return 1'b1;
   endfunction

   // Predict the outputs after the coming edge from the inputs it will sample.
   task automatic model_step();
      bit ps, pp, ss_sync, sp_sync, hit, fall_ev;
      if (!Rst_n) begin
         k = 0;
         s_hist.delete(); p_hist.delete(); s_win.delete(); p_win.delete();
         s_lvl = 0; p_lvl = 0; s_rose = 0; p_rose = 0;
         m_serve_pend = 0; m_hit_pend = 0; m_b = 0; m_p = 0; m_lock = 0;
      end else begin
         ps = s_rose;
         pp = p_rose;
         k++;
         fall_ev = (k % (2 * DIV)) == 0;
         hit = pp && !m_lock && (led_in == 8'h01);
         if (fall_ev) begin
            m_b = m_serve_pend;
            m_p = m_hit_pend;
            m_serve_pend = ps;
            m_hit_pend = hit;
         end else begin
            m_serve_pend |= ps;
            m_hit_pend |= hit;
         end
         if (led_in == 8'h80) m_lock = 0;
         else if (pp && !m_lock && led_in != 8'h01) m_lock = 1;

         s_hist.push_back(serve_btn);
         p_hist.push_back(paddle_btn);
         ss_sync = (s_hist.size() >= 3) ? s_hist[s_hist.size()-3] : 1'b0;
         sp_sync = (p_hist.size() >= 3) ? p_hist[p_hist.size()-3] : 1'b0;
         if (s_hist.size() > 3) void'(s_hist.pop_front());
         if (p_hist.size() > 3) void'(p_hist.pop_front());
         s_win.push_back(ss_sync);
         p_win.push_back(sp_sync);
         if (s_win.size() > DB) void'(s_win.pop_front());
         if (p_win.size() > DB) void'(p_win.pop_front());
         s_rose = 0;
         p_rose = 0;
         if (all_differ(s_win, s_lvl)) begin s_lvl = !s_lvl; s_rose = s_lvl; end
         if (all_differ(p_win, p_lvl)) begin p_lvl = !p_lvl; p_rose = p_lvl; end
      end
      m_step = ((k / DIV) % 2) == 1;
      exp_q.push_back({m_step, m_b, m_p, m_lock});
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         model_step();
         @(posedge Clk);
         #1;
      end
   endtask

   always @(negedge Clk) begin
      logic [3:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("outputs", {step_clk, b, p, lockout}, e);
      end
   end

   initial begin
      int s_left, p_left, n;
      #1;
      check("reset_state", {step_clk, b, p, lockout}, 4'b0000);
      tick(3);
      Rst_n = 1'b1;

      tick(40);                                        // idle free-running steps

      serve_btn = 1; tick(2); serve_btn = 0; tick(20); // glitch: no press
      serve_btn = 1; tick(6); serve_btn = 0; tick(24); // real serve

      led_in = 8'h01;
      paddle_btn = 1; tick(6); paddle_btn = 0; tick(20);

      led_in = 8'h08;
      paddle_btn = 1; tick(6); paddle_btn = 0; tick(12);
      led_in = 8'h01;
      paddle_btn = 1; tick(6); paddle_btn = 0; tick(12);
      led_in = 8'h80; tick(1);
      led_in = 8'h01; tick(4);

      // paddle press whose debounced rise lands on a fall event
      while (((k + 6) % (2 * DIV)) != 0) tick();
      paddle_btn = 1; tick(6); paddle_btn = 0; tick(24);
      while (((k + 6) % (2 * DIV)) != 0) tick();
      serve_btn = 1; tick(6); serve_btn = 0; tick(24);

      // randomized bouncing buttons and LED positions
      s_left = 0;
      p_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (s_left == 0) begin
            serve_btn = 1'($urandom_range(0, 1));
            s_left = $urandom_range(1, 8);
         end
         if (p_left == 0) begin
            paddle_btn = 1'($urandom_range(0, 1));
            p_left = $urandom_range(1, 8);
         end
         s_left--;
         p_left--;
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0: led_in = 8'h01;
               1: led_in = 8'h80;
               2: led_in = 8'h08;
               default: led_in = 8'($urandom);
            endcase
         end
         tick();
      end

      // asynchronous reset while b=1 and step_clk=1
      serve_btn = 0; paddle_btn = 0; led_in = 8'h00;
      tick(10);
      serve_btn = 1;
      n = 0;
      while (!(m_b && m_step) && n < 80) begin tick(); n++; end
      if (!(m_b && m_step)) begin
         miscompares++;
         $display("FAIL wait_b_high: b=%b step_clk=%b never both high within 80 cycles", m_b, m_step);
      end
      @(negedge Clk);
      #1;
      Rst_n = 1'b0;
      #1;
      check("async_reset", {step_clk, b, p, lockout}, 4'b0000);
      tick(3);
      Rst_n = 1'b1;                                    // serve still held through release
      tick(30);
      serve_btn = 0;
      tick(20);

      @(negedge Clk);
      #1;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
